e203_exu_csr_arbt: RTL and testbench

- Sequencer/arbiter owning the single CSR-file access port (csr_ena/csr_rd_en/csr_wr_en/csr_idx/wbck_csr_dat/read_csr_dat).
- Shares that port between two requesters: requester 0, the core CSR-instruction path, and requester 1, the debug-module abstract-command path.
- Each accepted request runs a registered read-modify-write (RW/RS/RC) as one atomic access, then returns a response over a valid/ready channel.
- Sits between the EXU CSR control logic / debug module and the CSR register file.

---
 rtl/e203_exu_csr_arbt_pkg.sv | 21 ++
 rtl/e203_exu_csr_rr_arb.sv | 23 ++
 rtl/e203_exu_csr_arbt.sv | 172 +++++++++++++++++
 tb/tb_e203_exu_csr_arbt.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_csr_arbt_pkg.sv
// Shared types for the CSR port arbiter.
// Op and state encodings plus widths.
package e203_exu_csr_arbt_pkg;

  localparam int XLEN_DFLT = 32;
  localparam int CSR_IDX_W = 12;

  typedef enum logic [1:0] {
    OP_RW  = 2'b00,
    OP_RS  = 2'b01,
    OP_RC  = 2'b10,
    OP_ILG = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_RSP  = 2'b10
  } arb_st_e;

endpackage

// File: rtl/e203_exu_csr_rr_arb.sv
// Two-way grant with eligibility mask.
// Fixed priority to requester 1 or round-robin.
module e203_exu_csr_rr_arb #(
  parameter int DBG_PRIO = 1
) (
  input  logic [1:0] valid,
  input  logic [1:0] elig,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  logic [1:0] req;

  always_comb begin
    req = valid & elig;
    gnt = req;
    // contention: requester 1 wins unless it was served last
    if (req == 2'b11) begin
      gnt = ((DBG_PRIO != 0) || !rr_last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/e203_exu_csr_arbt.sv
// CSR-file port sequencer shared by core and debug.
// One atomic read-modify-write per accepted request.
module e203_exu_csr_arbt
  import e203_exu_csr_arbt_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DBG_PRIO = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dbg_halt,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [CSR_IDX_W-1:0] req0_idx,
  input  logic [XLEN-1:0]      req0_wdat,
  input  logic                 req0_rden,
  input  logic                 req0_wren,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [XLEN-1:0]      rsp0_rdat,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [CSR_IDX_W-1:0] req1_idx,
  input  logic [XLEN-1:0]      req1_wdat,
  input  logic                 req1_rden,
  input  logic                 req1_wren,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [XLEN-1:0]      rsp1_rdat,
  output logic                 rsp1_err,
  output logic                 csr_ena,
  output logic                 csr_rd_en,
  output logic                 csr_wr_en,
  output logic [CSR_IDX_W-1:0] csr_idx,
  output logic [XLEN-1:0]      wbck_csr_dat,
  input  logic [XLEN-1:0]      read_csr_dat,
  input  logic                 csr_access_ilgl
);

  arb_st_e              state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 rr_last_q, rr_last_d;
  csr_op_e              op_q, op_d;
  logic [CSR_IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]      wdat_q, wdat_d;
  logic                 rden_q, rden_d;
  logic                 wren_q, wren_d;
  logic [XLEN-1:0]      rdat_q, rdat_d;
  logic                 err_q, err_d;
  logic [1:0]           gnt;
  logic                 bad_op;

  e203_exu_csr_rr_arb #(
    .DBG_PRIO(DBG_PRIO)
  ) u_arb (
    .valid  ({req1_valid, req0_valid}),
    .elig   ({1'b1, ~dbg_halt}),
    .rr_last(rr_last_q),
    .gnt    (gnt)
  );

  assign bad_op = (op_q == OP_ILG);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    op_d         = op_q;
    idx_d        = idx_q;
    wdat_d       = wdat_q;
    rden_d       = rden_q;
    wren_d       = wren_q;
    rdat_d       = rdat_q;
    err_d        = err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_rdat    = '0;
    rsp1_rdat    = '0;
    rsp0_err     = 1'b0;
    rsp1_err     = 1'b0;
    csr_ena      = 1'b0;
    csr_rd_en    = 1'b0;
    csr_wr_en    = 1'b0;
    csr_idx      = '0;
    wbck_csr_dat = '0;
    unique case (state_q)
      ST_IDLE: begin
        // ready is masked so nothing is offered while in reset
        req0_ready = gnt[0] & ~rst;
        req1_ready = gnt[1] & ~rst;
        if (gnt[1]) begin
          op_d      = csr_op_e'(req1_op);
          idx_d     = req1_idx;
          wdat_d    = req1_wdat;
          rden_d    = req1_rden;
          wren_d    = req1_wren;
          owner_d   = 1'b1;
          rr_last_d = 1'b1;
          state_d   = ST_ACC;
        end else if (gnt[0]) begin
          op_d      = csr_op_e'(req0_op);
          idx_d     = req0_idx;
          wdat_d    = req0_wdat;
          rden_d    = req0_rden;
          wren_d    = req0_wren;
          owner_d   = 1'b0;
          rr_last_d = 1'b0;
          state_d   = ST_ACC;
        end
      end
      ST_ACC: begin
        csr_ena   = 1'b1;
        csr_idx   = idx_q;
        csr_rd_en = rden_q;
        csr_wr_en = wren_q & ~csr_access_ilgl & ~bad_op;
        unique case (op_q)
          OP_RW:   wbck_csr_dat = wdat_q;
          OP_RS:   wbck_csr_dat = wdat_q | read_csr_dat;
          OP_RC:   wbck_csr_dat = ~wdat_q & read_csr_dat;
          default: wbck_csr_dat = '0;
        endcase
        rdat_d  = read_csr_dat;
        err_d   = csr_access_ilgl | bad_op;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        rsp0_rdat  = owner_q ? '0 : rdat_q;
        rsp1_rdat  = owner_q ? rdat_q : '0;
        rsp0_err   = ~owner_q & err_q;
        rsp1_err   = owner_q & err_q;
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      op_q      <= OP_RW;
      idx_q     <= '0;
      wdat_q    <= '0;
      rden_q    <= 1'b0;
      wren_q    <= 1'b0;
      rdat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      wdat_q    <= wdat_d;
      rden_q    <= rden_d;
      wren_q    <= wren_d;
      rdat_q    <= rdat_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_e203_exu_csr_arbt.sv
// Directed bench for the CSR port arbiter.
// Round-robin instance plus a debug-priority instance.
module tb_e203_exu_csr_arbt;

  logic        clk, rst, dbg_halt;
  logic        req0_valid, req0_rden, req0_wren, rsp0_ready;
  logic [1:0]  req0_op;
  logic [11:0] req0_idx;
  logic [31:0] req0_wdat;
  logic        req1_valid, req1_rden, req1_wren, rsp1_ready;
  logic [1:0]  req1_op;
  logic [11:0] req1_idx;
  logic [31:0] req1_wdat;
  logic [31:0] read_csr_dat;
  logic        csr_access_ilgl;

  logic        req0_ready, rsp0_valid, rsp0_err;
  logic        req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdat, rsp1_rdat, wbck_csr_dat;
  logic        csr_ena, csr_rd_en, csr_wr_en;
  logic [11:0] csr_idx;

  logic        p_req0_ready, p_rsp0_valid, p_rsp0_err;
  logic        p_req1_ready, p_rsp1_valid, p_rsp1_err;
  logic [31:0] p_rsp0_rdat, p_rsp1_rdat, p_wbck;
  logic        p_csr_ena, p_csr_rd_en, p_csr_wr_en;
  logic [11:0] p_csr_idx;

  int errors = 0;
  int checks = 0;
  bit log_en = 0;
  int rr_log[$];
  int pr_log[$];

  typedef struct {
    logic [1:0]  op;
    logic [11:0] idx;
    logic [31:0] wdat;
    logic        rden;
    logic        wren;
    logic [31:0] old;
    logic        ilgl;
    logic        exp_wr;
    bit          chk_wb;
    logic [31:0] exp_wb;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  e203_exu_csr_arbt #(.XLEN(32), .DBG_PRIO(0)) dut (
    .clk(clk), .rst(rst), .dbg_halt(dbg_halt),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_idx(req0_idx),
    .req0_wdat(req0_wdat), .req0_rden(req0_rden),
    .req0_wren(req0_wren),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_rdat(rsp0_rdat), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_idx(req1_idx),
    .req1_wdat(req1_wdat), .req1_rden(req1_rden),
    .req1_wren(req1_wren),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_rdat(rsp1_rdat), .rsp1_err(rsp1_err),
    .csr_ena(csr_ena), .csr_rd_en(csr_rd_en),
    .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
    .wbck_csr_dat(wbck_csr_dat),
    .read_csr_dat(read_csr_dat),
    .csr_access_ilgl(csr_access_ilgl)
  );

  e203_exu_csr_arbt #(.XLEN(32), .DBG_PRIO(1)) dut_p (
    .clk(clk), .rst(rst), .dbg_halt(dbg_halt),
    .req0_valid(req0_valid), .req0_ready(p_req0_ready),
    .req0_op(req0_op), .req0_idx(req0_idx),
    .req0_wdat(req0_wdat), .req0_rden(req0_rden),
    .req0_wren(req0_wren),
    .rsp0_valid(p_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_rdat(p_rsp0_rdat), .rsp0_err(p_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(p_req1_ready),
    .req1_op(req1_op), .req1_idx(req1_idx),
    .req1_wdat(req1_wdat), .req1_rden(req1_rden),
    .req1_wren(req1_wren),
    .rsp1_valid(p_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_rdat(p_rsp1_rdat), .rsp1_err(p_rsp1_err),
    .csr_ena(p_csr_ena), .csr_rd_en(p_csr_rd_en),
    .csr_wr_en(p_csr_wr_en), .csr_idx(p_csr_idx),
    .wbck_csr_dat(p_wbck),
    .read_csr_dat(read_csr_dat),
    .csr_access_ilgl(csr_access_ilgl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    #1;
    if (log_en) begin
      if (req0_valid && req0_ready) rr_log.push_back(0);
      if (req1_valid && req1_ready) rr_log.push_back(1);
      if (req0_valid && p_req0_ready) pr_log.push_back(0);
      if (req1_valid && p_req1_ready) pr_log.push_back(1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    @(negedge clk);
    req0_op = v.op; req0_idx = v.idx; req0_wdat = v.wdat;
    req0_rden = v.rden; req0_wren = v.wren; req0_valid = 1'b1;
    #1 chk($sformatf("v%0d req0_ready", n), 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0; req0_op = ~v.op; req0_idx = 12'hFFF;
    req0_wdat = ~v.wdat; req0_wren = ~v.wren;
    read_csr_dat = v.old; csr_access_ilgl = v.ilgl;
    #1;
    chk($sformatf("v%0d csr_ena", n), 32'(csr_ena), 1);
    chk($sformatf("v%0d csr_idx", n), 32'(csr_idx), 32'(v.idx));
    chk($sformatf("v%0d rd_en", n), 32'(csr_rd_en), 32'(v.rden));
    chk($sformatf("v%0d wr_en", n), 32'(csr_wr_en), 32'(v.exp_wr));
    if (v.chk_wb) chk($sformatf("v%0d wbck", n), wbck_csr_dat, v.exp_wb);
    @(negedge clk);
    read_csr_dat = 32'h5555AAAA; csr_access_ilgl = 1'b0;
    #1;
    chk($sformatf("v%0d rsp0_valid", n), 32'(rsp0_valid), 1);
    chk($sformatf("v%0d rsp0_rdat", n), rsp0_rdat, v.old);
    chk($sformatf("v%0d rsp0_err", n), 32'(rsp0_err), 32'(v.exp_err));
    chk($sformatf("v%0d rsp1_valid", n), 32'(rsp1_valid), 0);
    chk($sformatf("v%0d csr_ena_rsp", n), 32'(csr_ena), 0);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1 chk($sformatf("v%0d rsp0_drop", n), 32'(rsp0_valid), 0);
  endtask

  initial begin
    //   op     idx      wdat          rd wr old           il wr chk wb           err
    vecs[0] = '{2'b00, 12'h340, 32'hDEADBEEF, 1, 1, 32'h12345678, 0, 1, 1,
                32'hDEADBEEF, 0};
    vecs[1] = '{2'b01, 12'h300, 32'h000000FF, 1, 1, 32'h0000F0F0, 0, 1, 1,
                32'h0000F0FF, 0};
    vecs[2] = '{2'b10, 12'h300, 32'h000000FF, 1, 1, 32'h0000F0F0, 0, 1, 1,
                32'h0000F000, 0};
    vecs[3] = '{2'b01, 12'h305, 32'h000000FF, 1, 0, 32'h0000F0F0, 0, 0, 1,
                32'h0000F0FF, 0};
    vecs[4] = '{2'b00, 12'h341, 32'hCAFEF00D, 0, 1, 32'h00000007, 0, 1, 1,
                32'hCAFEF00D, 0};
    vecs[5] = '{2'b00, 12'hFFF, 32'h11112222, 1, 1, 32'h33334444, 1, 0, 1,
                32'h11112222, 1};
    vecs[6] = '{2'b11, 12'h340, 32'h0F0F0F0F, 1, 1, 32'h76543210, 0, 0, 0,
                32'h0, 1};

    rst = 1'b1; dbg_halt = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_idx = 12'h340;
    req0_wdat = 32'h0; req0_rden = 1'b1; req0_wren = 1'b1;
    req1_valid = 1'b0; req1_op = 2'b00; req1_idx = 12'h0;
    req1_wdat = 32'h0; req1_rden = 1'b0; req1_wren = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    read_csr_dat = 32'h0; csr_access_ilgl = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst req0_ready", 32'(req0_ready), 0);
    chk("rst csr_ena", 32'(csr_ena), 0);
    chk("rst rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst wbck", wbck_csr_dat, 0);
    @(negedge clk);
    req0_valid = 1'b0; rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // dbg_halt blocks requester 0, then a late halt does not abort
    @(negedge clk);
    dbg_halt = 1'b1; req0_valid = 1'b1; req0_op = 2'b00;
    req0_wdat = 32'h1; req0_rden = 1'b1; req0_wren = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("halt req0_ready", 32'(req0_ready), 0);
      chk("halt csr_ena", 32'(csr_ena), 0);
      @(negedge clk);
    end
    dbg_halt = 1'b0;
    #1 chk("unhalt req0_ready", 32'(req0_ready), 1);
    @(negedge clk);
    dbg_halt = 1'b1; req0_valid = 1'b0; read_csr_dat = 32'h00C0FFEE;
    #1 chk("halt_acc csr_ena", 32'(csr_ena), 1);
    @(negedge clk);
    #1 chk("halt_rsp valid", 32'(rsp0_valid), 1);
    chk("halt_rsp rdat", rsp0_rdat, 32'h00C0FFEE);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; dbg_halt = 1'b0;

    // response backpressure on requester 1
    @(negedge clk);
    req1_op = 2'b01; req1_idx = 12'h7B0; req1_wdat = 32'h1;
    req1_rden = 1'b1; req1_wren = 1'b1; req1_valid = 1'b1;
    #1 chk("bp req1_ready", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0; req0_valid = 1'b1; read_csr_dat = 32'hA5A50000;
    #1 chk("bp wr_en", 32'(csr_wr_en), 1);
    chk("bp wbck", wbck_csr_dat, 32'hA5A50001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      read_csr_dat = $urandom;
      #1 chk("bp rsp1_valid", 32'(rsp1_valid), 1);
      chk("bp rsp1_rdat", rsp1_rdat, 32'hA5A50000);
      chk("bp rsp1_err", 32'(rsp1_err), 0);
      chk("bp req0_ready", 32'(req0_ready), 0);
      chk("bp rsp0_valid", 32'(rsp0_valid), 0);
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1 chk("bp next grant", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1 chk("bp req0 rsp", 32'(rsp0_valid), 1);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    // asynchronous reset while a response is pending
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b00; req0_wren = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0; read_csr_dat = 32'h0BADF00D;
    @(negedge clk);
    #1 chk("mid rsp0_valid", 32'(rsp0_valid), 1);
    req0_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst rsp0_valid", 32'(rsp0_valid), 0);
    chk("arst rsp0_rdat", rsp0_rdat, 0);
    chk("arst req0_ready", 32'(req0_ready), 0);
    chk("arst csr_ena", 32'(csr_ena), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst idle", 32'(req0_ready), 1);
    chk("post_rst rsp0", 32'(rsp0_valid), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    // arbitration order under constant contention
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1; dbg_halt = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; log_en = 1'b1;
    repeat (13) @(negedge clk);
    #2;
    log_en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr count", 32'(rr_log.size() >= 4), 1);
    chk("prio count", 32'(pr_log.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr grant%0d", i),
          (i < rr_log.size()) ? 32'(rr_log[i]) : 32'hFF, 32'(i % 2));
      chk($sformatf("prio grant%0d", i),
          (i < pr_log.size()) ? 32'(pr_log[i]) : 32'hFF, 1);
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
